// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO entry types, default sizes and leading-ones helper
package fifo_pkg;

  localparam int FIFO_DATA_W     = 32;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_LANES      = 2;
  localparam int LEAD_ONES_MAX_W = 32;

  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

  // Length of the unbroken run of ones starting at bit 0.
  function automatic int lead_ones(input logic [LEAD_ONES_MAX_W-1:0] vec);
    int n;
    bit run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < LEAD_ONES_MAX_W; i++) begin
      if (run && vec[i]) n = i + 1;
      else               run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/lead_ones_count.sv
// rtl/lead_ones_count.sv - counts the prefix of asserted lanes starting at lane 0
module lead_ones_count
  import fifo_pkg::*;
#(
  parameter int N = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_vec,
  output logic [CW-1:0] o_count
);

  assign o_count = CW'(lead_ones(LEAD_ONES_MAX_W'(i_vec)));

endmodule

// File: rtl/mp_fifo.sv
// rtl/mp_fifo.sv - multi-ported FWFT FIFO with flush; MP_FIFO_ASSERT_EN enables sim checks
module mp_fifo
  import fifo_pkg::*;
#(
  parameter type T        = fifo_word_t,
  parameter int  DEPTH    = FIFO_DEPTH,
  parameter int  WR_PORTS = FIFO_LANES,
  parameter int  RD_PORTS = FIFO_LANES
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_flush,
  input  logic [WR_PORTS-1:0]     i_wr_en,
  input  T                        i_wr_data [WR_PORTS],
  output logic                    o_wr_ready,
  output logic [RD_PORTS-1:0]     o_rd_valid,
  output T                        o_rd_data [RD_PORTS],
  input  logic [RD_PORTS-1:0]     i_rd_en,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CNW = PW + 2;
  localparam int WNW = $clog2(WR_PORTS + 1);
  localparam int RNW = $clog2(RD_PORTS + 1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_clear;
  logic [WR_PORTS-1:0] w_wr_req;
  logic [RD_PORTS-1:0] w_rd_req;
  logic [WNW-1:0]  w_n_wr;
  logic [RNW-1:0]  w_n_rd;
  logic [CNW-1:0]  w_count_next;

  assign w_clear = i_reset | i_flush;

  // Status flags come only from the registered count, so there is no rd_en -> wr_ready path.
  assign o_wr_ready = (CNW'(DEPTH) - CNW'(r_count)) >= CNW'(WR_PORTS);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_valid
    assign o_rd_valid[g] = (r_count > CW'(g));
  end

  assign w_wr_req = i_wr_en & {WR_PORTS{o_wr_ready}};
  assign w_rd_req = i_rd_en & o_rd_valid;

  lead_ones_count #(.N(WR_PORTS)) u_wr_lead (
    .i_vec   (w_wr_req),
    .o_count (w_n_wr)
  );

  lead_ones_count #(.N(RD_PORTS)) u_rd_lead (
    .i_vec   (w_rd_req),
    .o_count (w_n_rd)
  );

  assign w_count_next = CNW'(r_count) + CNW'(w_n_wr) - CNW'(w_n_rd);

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_n_wr);
      r_rd_ptr <= r_rd_ptr + PW'(w_n_rd);
      r_count  <= CW'(w_count_next);
    end
  end

  // Storage is deliberately left unreset; validity is carried entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (!w_clear) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (i < int'(w_n_wr)) r_mem[r_wr_ptr + PW'(i)] <= i_wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      o_rd_data[i] = o_rd_valid[i] ? r_mem[r_rd_ptr + PW'(i)] : '0;
    end
  end

`ifdef MP_FIFO_ASSERT_EN
  if (!(((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= WR_PORTS) && (DEPTH >= RD_PORTS))) begin : g_bad_cfg
    $error("mp_fifo: DEPTH must be a power of two >= max(WR_PORTS, RD_PORTS)");
  end

  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert ((i_wr_en & (i_wr_en + WR_PORTS'(1))) == '0)
        else $error("mp_fifo: non-prefix wr_en %b", i_wr_en);
      assert ((i_rd_en & (i_rd_en + RD_PORTS'(1))) == '0)
        else $error("mp_fifo: non-prefix rd_en %b", i_rd_en);
      assert (!(i_wr_en[0] && !o_wr_ready))
        else $error("mp_fifo: write while not ready");
      assert ((i_rd_en & ~o_rd_valid) == '0)
        else $error("mp_fifo: read of invalid lane, rd_en %b rd_valid %b", i_rd_en, o_rd_valid);
      assert (r_count <= CW'(DEPTH))
        else $error("mp_fifo: count %0d exceeds depth", r_count);
    end
  end
`endif

endmodule

// File: doc/mp_fifo.md
# mp_fifo

Multi-ported synchronous FIFO with first-word-fall-through read. Up to WR_PORTS entries enqueue and up to RD_PORTS entries dequeue in the same cycle, with an independent flush. It replaces the single-port FIFO wherever the superscalar front end needs a width-N queue, for example the fetch-to-decode instruction buffer or the decode-to-rename buffer. Flush is the mispredict/recovery squash.

## Interface
- T, logic [31:0]: entry type.
- DEPTH, 16: number of entries. Power of two, ≥ max(WR_PORTS, RD_PORTS).
- WR_PORTS, 2: enqueue lanes (≥1).
- RD_PORTS, 2: dequeue lanes (≥1).

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous squash of all contents.
- wr_en  in  WR_PORTS  per-lane enqueue request.
- wr_data  in  T[WR_PORTS]  lane data; lane 0 is oldest.
- wr_ready  out  1  FIFO can accept a full WR_PORTS group this cycle.
- rd_valid  out  RD_PORTS  lane i holds the i-th oldest entry.
- rd_data  out  T[RD_PORTS]  head entries, FWFT.
- rd_en  in  RD_PORTS  per-lane dequeue request.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is registered.
  - Storage is an unpacked array of T, never reset or cleared.
- Accepted writes:
  - n_wr = number of leading ones of wr_en, counted from lane 0, when wr_ready = 1; otherwise 0.
  - Lanes after the first zero are ignored. Example: with WR_PORTS=2, wr_en=2'b10 accepts nothing.
  - Lane i writes mem[wr_ptr+i]. wr_ptr advances by n_wr.
- wr_ready = (DEPTH − count) ≥ WR_PORTS.
  - It depends on registered count only: no credit from same-cycle reads, and no combinational path from rd_en.
  - This is all-or-nothing: a partial group is never accepted when free space is between 1 and WR_PORTS−1.
- rd_valid[i] = (count > i).
- rd_data[i] = mem[rd_ptr+i] when rd_valid[i] = 1; otherwise '0.
- Accepted reads:
  - n_rd = number of leading ones of (rd_en & rd_valid).
  - rd_ptr advances by n_rd.
  - Requests on invalid or non-prefix lanes are ignored, never underflow.
- count_next = count + n_wr − n_rd. Evaluate it in $clog2(DEPTH)+2 bits, then truncate. Overflow and underflow are impossible by construction.
- Priority: reset > flush > normal operation.
  - reset or flush sets wr_ptr, rd_ptr and count to 0.
  - In that cycle no write is stored and no read is counted.

## Timing
- Reset values: count=0, empty=1, full=0, wr_ready=1, rd_valid=0, rd_data='0.
- Write-to-read latency is 1 cycle. An entry written at edge k is on rd_data/rd_valid after edge k.
  - There is no same-cycle bypass while empty.
- Read: rd_data is valid combinationally in the same cycle as rd_valid. The dequeue takes effect at the edge where rd_en is sampled.
- Simultaneous read and write are allowed at any occupancy. wr_ready is still judged on pre-read count.
- Reset or flush asserted mid-burst: effective at that edge; outputs show the reset values from the next cycle.
- full, empty, wr_ready and rd_valid are pure functions of registered count.

## Configuration
- MP_FIFO_ASSERT_EN defined: simulation assertions fire $error on:
  - a non-prefix wr_en or rd_en pattern;
  - wr_en[0]=1 while wr_ready=0;
  - rd_en[i]=1 while rd_valid[i]=0;
  - count > DEPTH;
  - an elaboration check that DEPTH is a power of two ≥ max(WR_PORTS, RD_PORTS).
- Without the macro: no assertions. Illegal requests are silently clamped as described in Operation. Functional behaviour is identical.

## Structure
- Shared package fifo_pkg:
  - function lead_ones(vec): leading-ones count from bit 0.
  - Default-width localparams for the entry type, reused by the instruction-buffer instances.
- One sub-module is natural: lead_ones_count.
  - Parametrised width N; output is $clog2(N+1) bits.
  - Instantiated twice, once for the write lanes and once for the read lanes.
- Single always_ff for pointers and count, one for storage. Read muxes are combinational.

## Test plan
- Reset, with DEPTH=16, WR=RD=2: after reset, count=0, empty=1, full=0, wr_ready=1, rd_valid=2'b00, rd_data=0.
- Fill: wr_en=2'b11 for 8 cycles with data 0..15 → count=16, full=1, wr_ready=0. A 9th wr_en=11 → count stays 16 and contents are unchanged.
- Boundary: count=15 with wr_en=11 and rd_en=11 → no write (wr_ready=0), 2 dequeued, count=13. Next cycle the same stimulus gives count=13 (+2 −2).
- Non-prefix requests:
  - wr_en=2'b10 → count unchanged.
  - With 3 entries A, B, C: rd_en=2'b10 → nothing dequeued.
  - rd_en=2'b01 → A popped; rd_data[0]=B next cycle.
- Wrap and order: 200 cycles of random prefix writes and reads with scoreboard checking → FIFO order preserved across more than 10 pointer wraps, and count always matches the model.
- Flush: at count=9, flush=1 with wr_en=11 and rd_en=11 → next cycle count=0, empty=1, rd_valid=00. A subsequent write of 0x55 appears on rd_data[0] one cycle later.
